// File: rtl/mii_rx_pkg.sv
// Shared types and constants for the MII receive frame checker.
package mii_rx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DROP     = 2'd3
  } rx_state_t;

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;
  localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
  localparam logic [3:0]  NIB_PRE     = 4'h5;
  localparam logic [3:0]  NIB_SFD     = 4'hD;

  typedef struct packed {
    logic len_err;
    logic rx_er_seen;
    logic align_err;
    logic fcs_err;
  } rx_err_t;

endpackage

// File: rtl/crc32_nibble_rx.sv
// Ethernet CRC32 register advanced one MII nibble per enabled cycle.
// Held in MSB-first orientation, so a good frame leaves CRC_RESIDUE behind.
module crc32_nibble_rx
  import mii_rx_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic [3:0]  data,
  output logic [31:0] crc
);

  // rxd[0] is the first bit on the wire
  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 4; i++) begin
      if (r[31] ^ d[i]) r = (r << 1) ^ CRC_POLY;
      else              r = r << 1;
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     crc <= CRC_INIT;
    else if (init) crc <= CRC_INIT;
    else if (en)   crc <= crc_next(crc, data);
  end

endmodule

// File: rtl/mii_rx_fcs_check.sv
// MII receive frame checker: preamble/SFD strip, nibble-to-byte assembly, FCS check, counters.
// Optional RX_LEN_CHECK_EN adds a frame length check against MIN_LEN/MAX_LEN.
module mii_rx_fcs_check
  import mii_rx_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned MAX_LEN = 1518,
  parameter int unsigned MIN_LEN = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_dv,
  input  logic             rx_er,
  input  logic [3:0]       rxd,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_sop,
  output logic             out_eop,
  output logic             out_good,
  output logic [3:0]       out_err,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt
);

  rx_state_t   state;
  logic        nib_odd;
  logic [3:0]  low_nib;
  logic [7:0]  hold_data;
  logic        hold_valid;
  logic        hold_first;
  logic        first_pend;
  logic        rx_er_seen;
  logic [31:0] crc;

  logic    sfd_hit, pre_bad, crc_en, data_hi, frame_end, emit;
  logic    len_err, frame_ok, good_inc, bad_inc;
  rx_err_t err_c;

  assign sfd_hit   = ((state == IDLE) || (state == PREAMBLE)) && rx_dv && (rxd == NIB_SFD);
  assign pre_bad   = (state == PREAMBLE) && rx_dv && (rxd != NIB_PRE) && (rxd != NIB_SFD);
  assign crc_en    = (state == DATA) && rx_dv;
  assign data_hi   = crc_en && nib_odd;
  assign frame_end = (state == DATA) && !rx_dv;
  // a held byte leaves only once we know whether it is the last one
  assign emit      = hold_valid && (data_hi || frame_end);

  crc32_nibble_rx u_crc (
    .clk   (clk),
    .reset (reset),
    .init  (sfd_hit),
    .en    (crc_en),
    .data  (rxd),
    .crc   (crc)
  );

`ifdef RX_LEN_CHECK_EN
  localparam int unsigned LEN_W = 11;
  logic [LEN_W-1:0] byte_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       byte_cnt <= '0;
    else if (sfd_hit)                byte_cnt <= '0;
    else if (data_hi && ~&byte_cnt)  byte_cnt <= byte_cnt + 1'b1;
  end

  assign len_err = (byte_cnt < LEN_W'(MIN_LEN)) || (byte_cnt > LEN_W'(MAX_LEN));
`else
  logic unused_len;
  assign unused_len = ^{MIN_LEN, MAX_LEN};
  assign len_err    = 1'b0;
`endif

  always_comb begin
    err_c            = '0;
    err_c.len_err    = len_err;
    err_c.rx_er_seen = rx_er_seen;
    err_c.align_err  = nib_odd;
    err_c.fcs_err    = (crc != CRC_RESIDUE);
  end

  // frames ending with no complete byte count as bad
  assign frame_ok = hold_valid && (err_c == '0);
  assign good_inc = frame_end && frame_ok;
  assign bad_inc  = (frame_end && !frame_ok) || pre_bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= DROP;
      nib_odd    <= 1'b0;
      low_nib    <= '0;
      hold_data  <= '0;
      hold_valid <= 1'b0;
      hold_first <= 1'b0;
      first_pend <= 1'b0;
      rx_er_seen <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_good   <= 1'b0;
      out_err    <= '0;
      good_cnt   <= '0;
      bad_cnt    <= '0;
    end else begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_good  <= 1'b0;
      out_err   <= '0;

      case (state)
        IDLE: begin
          if (rx_dv) begin
            if (rxd == NIB_PRE)      state <= PREAMBLE;
            else if (rxd == NIB_SFD) state <= DATA;
            else                     state <= DROP;
          end
        end
        PREAMBLE: begin
          if (!rx_dv)              state <= IDLE;
          else if (rxd == NIB_SFD) state <= DATA;
          else if (rxd != NIB_PRE) state <= DROP;
        end
        DATA:    if (!rx_dv) state <= IDLE;
        default: if (!rx_dv) state <= IDLE;
      endcase

      if (sfd_hit) begin
        nib_odd    <= 1'b0;
        hold_valid <= 1'b0;
        first_pend <= 1'b1;
        rx_er_seen <= 1'b0;
      end

      if (crc_en) begin
        nib_odd <= ~nib_odd;
        if (!nib_odd) low_nib <= rxd;
        if (rx_er)    rx_er_seen <= 1'b1;
      end

      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= hold_data;
        out_sop   <= hold_first;
        out_eop   <= frame_end;
        if (frame_end) begin
          out_good <= (err_c == '0);
          out_err  <= err_c;
        end
      end

      if (data_hi) begin
        hold_data  <= {rxd, low_nib};
        hold_valid <= 1'b1;
        hold_first <= first_pend;
        first_pend <= 1'b0;
      end else if (emit) begin
        hold_valid <= 1'b0;
      end

      if (frame_end) nib_odd <= 1'b0;

      if (good_inc && ~&good_cnt) good_cnt <= good_cnt + 1'b1;
      if (bad_inc && ~&bad_cnt)   bad_cnt  <= bad_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mii_rx_fcs_check.sv
// Directed self-checking bench for mii_rx_fcs_check (narrow counters to reach saturation).
module tb_mii_rx_fcs_check;

  localparam int unsigned CNT_W = 4;
`ifdef RX_LEN_CHECK_EN
  localparam logic [3:0] LEN_BIT = 4'b1000;
`else
  localparam logic [3:0] LEN_BIT = 4'b0000;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             rx_dv = 1'b0;
  logic             rx_er = 1'b0;
  logic [3:0]       rxd = 4'h0;
  logic [7:0]       out_data;
  logic             out_valid, out_sop, out_eop, out_good;
  logic [3:0]       out_err;
  logic [CNT_W-1:0] good_cnt, bad_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_good = 0;
  int exp_bad  = 0;

  logic [7:0] frm[$];
  logic [7:0] q_data[$];
  logic       q_sop[$];
  logic       q_eop[$];
  logic       eop_good;
  logic [3:0] eop_err;

  mii_rx_fcs_check #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_dv     (rx_dv),
    .rx_er     (rx_er),
    .rxd       (rxd),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_good  (out_good),
    .out_err   (out_err),
    .good_cnt  (good_cnt),
    .bad_cnt   (bad_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset) begin
      q_data.delete();
      q_sop.delete();
      q_eop.delete();
    end else if (out_valid) begin
      q_data.push_back(out_data);
      q_sop.push_back(out_sop);
      q_eop.push_back(out_eop);
      if (out_eop) begin
        eop_good = out_good;
        eop_err  = out_err;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit dv, input logic [3:0] d, input bit er);
    @(posedge clk);
    #2;
    rx_dv = dv;
    rxd   = d;
    rx_er = er;
  endtask

  // reflected CRC32 with final inversion; FCS goes out LSB byte first
  task automatic append_fcs();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (frm[i]) begin
      c = c ^ {24'h0, frm[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
  endtask

  task automatic load_zeros(input int n);
    frm.delete();
    for (int i = 0; i < n; i++) frm.push_back(8'h00);
    append_fcs();
  endtask

  task automatic load_t1();
    frm.delete();
    for (int i = 0; i < 9; i++) frm.push_back(8'(8'h31 + i));
    frm.push_back(8'h26);
    frm.push_back(8'h39);
    frm.push_back(8'hF4);
    frm.push_back(8'hCB);
  endtask

  task automatic send_frame(input int pre, input bit pre_bad, input int er_nib,
                            input int extra, input int rst_at);
    logic [7:0] b;
    int k;
    k = 0;
    for (int i = 0; i < pre; i++) drive(1'b1, (pre_bad && i == pre - 1) ? 4'h7 : 4'h5, 1'b0);
    drive(1'b1, 4'hD, 1'b0);
    for (int i = 0; i < frm.size(); i++) begin
      b = frm[i];
      for (int h = 0; h < 2; h++) begin
        reset = (rst_at >= 0) && (k >= rst_at) && (k < rst_at + 2);
        drive(1'b1, h ? b[7:4] : b[3:0], k == er_nib);
        k++;
      end
    end
    reset = 1'b0;
    if (extra >= 0) drive(1'b1, 4'(extra), 1'b0);
    repeat (12) drive(1'b0, 4'h0, 1'b0);
  endtask

  task automatic check_frame(input string tag, input int n_exp, input logic good_exp,
                             input logic [3:0] err_exp);
    int bad_bytes, sops, eops, n;
    n = q_data.size();
    chk({tag, ".beats"}, 32'(n), 32'(n_exp));
    if (n_exp > 0 && n == n_exp) begin
      bad_bytes = 0;
      sops = 0;
      eops = 0;
      for (int i = 0; i < n; i++) begin
        if (q_data[i] !== frm[i]) bad_bytes++;
        if (q_sop[i]) sops++;
        if (q_eop[i]) eops++;
      end
      chk({tag, ".data_errs"}, 32'(bad_bytes), 0);
      chk({tag, ".sop"}, {31'h0, q_sop[0]} + 32'(sops), 2);
      chk({tag, ".eop"}, {31'h0, q_eop[n-1]} + 32'(eops), 2);
      chk({tag, ".good"}, {31'h0, eop_good}, {31'h0, good_exp});
      chk({tag, ".err"}, {28'h0, eop_err}, {28'h0, err_exp});
    end
    chk({tag, ".good_cnt"}, 32'(good_cnt), 32'(exp_good));
    chk({tag, ".bad_cnt"}, 32'(bad_cnt), 32'(exp_bad));
    q_data.delete();
    q_sop.delete();
    q_eop.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst.valid", {31'h0, out_valid}, 0);
    chk("rst.err", {28'h0, out_err}, 0);
    chk("rst.good_cnt", 32'(good_cnt), 0);
    chk("rst.bad_cnt", 32'(bad_cnt), 0);
    reset = 1'b0;
    repeat (4) drive(1'b0, 4'h0, 1'b0);

    load_t1();
    send_frame(15, 1'b0, -1, -1, -1);
    exp_good = 1;
    check_frame("t1", 13, 1'b1, 4'b0000);
    chk("t1.first", {24'h0, frm[0]}, 32'h31);

    load_t1();
    frm[12] = 8'hCA;
    send_frame(15, 1'b0, -1, -1, -1);
    exp_bad = 1;
    check_frame("t2", 13, 1'b0, 4'b0001);

    load_t1();
    send_frame(15, 1'b0, -1, 3, -1);
    exp_bad = 2;
    check_frame("t3", 13, 1'b0, 4'b0011);

    load_t1();
    send_frame(15, 1'b0, 8, -1, -1);
    exp_bad = 3;
    check_frame("t4.rx_er", 13, 1'b0, 4'b0100);

    load_t1();
    send_frame(4, 1'b1, -1, -1, -1);
    exp_bad = 4;
    check_frame("t4.pre", 0, 1'b0, 4'b0000);

    load_t1();
    send_frame(15, 1'b0, -1, -1, 8);
    exp_good = 0;
    exp_bad  = 0;
    check_frame("t5.abort", 0, 1'b0, 4'b0000);
    load_t1();
    send_frame(15, 1'b0, -1, -1, -1);
    exp_good = 1;
    check_frame("t5.next", 13, 1'b1, 4'b0000);

`ifdef RX_LEN_CHECK_EN
    load_zeros(60);
    send_frame(7, 1'b0, -1, -1, -1);
    exp_good = 2;
    check_frame("t6.min", 64, 1'b1, 4'b0000);
    load_zeros(59);
    send_frame(7, 1'b0, -1, -1, -1);
    exp_bad = 1;
    check_frame("t6.short", 63, 1'b0, 4'b1000);
    load_zeros(1515);
    send_frame(7, 1'b0, -1, -1, -1);
    exp_bad = 2;
    check_frame("t6.long", 1519, 1'b0, 4'b1000);
`else
    load_zeros(59);
    send_frame(7, 1'b0, -1, -1, -1);
    exp_good = 2;
    check_frame("t6.nolen", 63, 1'b1, 4'b0000);
`endif

    frm.delete();
    frm.push_back(8'hAB);
    send_frame(7, 1'b0, -1, -1, -1);
    exp_bad++;
    check_frame("single", 1, 1'b0, LEN_BIT | 4'b0001);

    frm.delete();
    send_frame(7, 1'b0, -1, -1, -1);
    exp_bad++;
    check_frame("zero", 0, 1'b0, 4'b0000);

    repeat (20) begin
      send_frame(7, 1'b0, -1, -1, -1);
      exp_bad = (exp_bad == 15) ? 15 : exp_bad + 1;
    end
    check_frame("sat", 0, 1'b0, 4'b0000);
    chk("sat.ones", 32'(bad_cnt), 32'hF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
